// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Summary  : Per-channel two-flop synchroniser and debounce filter for the
//            push-button lines. Produces a clean level, a one-cycle press
//            pulse per button, and the OR / lowest-index view of the pulses.
//            Build macro BTN_ACTIVE_LOW_EN: when defined, a raw line reading
//            low means "pressed"; when undefined, a raw line reading high
//            means "pressed".
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int N_BTN           = 9,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17,
  parameter int IDX_W           = 4
) (
  input  logic             cin,
  input  logic             KEY0,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             press_any,
  output logic [IDX_W-1:0] press_idx
);

  // Terminal count: a mismatch seen with the counter at this value flips the level.
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Per-channel filter state.
  localparam logic ST_STABLE  = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  logic [N_BTN-1:0] w_logical;
  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;
  logic [N_BTN-1:0] state_q;
  logic [N_BTN-1:0] state_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;

  // Map the raw pins into the logical domain, where 1 always means pressed.
`ifdef BTN_ACTIVE_LOW_EN
  assign w_logical = ~btn_raw;
`else
  assign w_logical = btn_raw;
`endif

  // State register: synchroniser, filter state, counters, level and pulse.
  always_ff @(posedge cin or negedge KEY0) begin
    if (!KEY0) begin
      s1_q    <= '0;
      s2_q    <= '0;
      state_q <= {N_BTN{ST_STABLE}};
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= w_logical;
      s2_q    <= s1_q;
      state_q <= state_d;
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Next-state logic: count consecutive mismatches, flip the level at terminal count.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      logic [CNT_W-1:0] w_cnt_cur;
      // A channel in STABLE has no live count, whatever the counter holds.
      w_cnt_cur  = (state_q[i] == ST_PENDING) ? cnt_q[i] : '0;
      state_d[i] = ST_STABLE;
      cnt_d[i]   = '0;
      level_d[i] = level_q[i];
      press_d[i] = 1'b0;
      if (s2_q[i] != level_q[i]) begin
        if (w_cnt_cur == C_CNT_MAX) begin
          // Only a rising debounced level generates a pulse.
          level_d[i] = s2_q[i];
          press_d[i] = s2_q[i];
        end else begin
          cnt_d[i]   = w_cnt_cur + 1'b1;
          state_d[i] = ST_PENDING;
        end
      end
    end
  end

  // Output logic: registered level/pulse plus OR and lowest-set-bit index.
  always_comb begin
    btn_level = level_q;
    btn_press = press_q;
    press_any = |press_q;
    press_idx = '1;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_q[i]) begin
        press_idx = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire
